// File: rtl/rvx10_instr_encoder.sv
// Encodes ALU control codes into R-type / RVX10 instruction words and streams them, with byte
// addresses, through a small FIFO. Optional head re-decode self-check: RVX10_ENC_CHECK_EN.
module rvx10_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [15:0] word_count,
  output logic        chk_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_BASE  = 7'b0110011;
  localparam logic [6:0] OPC_RVX10 = 7'b0001011;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid
  // never depends on ready, and in_ready depends only on registered FIFO occupancy.

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_addr;
  logic          r_err_illegal;
  logic [15:0]   r_word_count;

  logic          w_legal;
  logic [6:0]    w_opcode;
  logic [6:0]    w_f7;
  logic [2:0]    w_f3;
  logic [4:0]    w_rs2;
  logic [31:0]   w_word;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  always_comb begin
    w_legal  = 1'b1;
    w_opcode = OPC_RVX10;
    w_f7     = 7'd0;
    w_f3     = 3'd0;
    w_rs2    = in_rs2;
    case (in_op)
      5'b00000: begin w_opcode = OPC_BASE; end
      5'b00001: begin w_opcode = OPC_BASE; w_f7 = 7'b0100000; end
      5'b00010: begin w_opcode = OPC_BASE; w_f3 = 3'b111; end
      5'b00011: begin w_opcode = OPC_BASE; w_f3 = 3'b110; end
      5'b00101: begin w_opcode = OPC_BASE; w_f3 = 3'b010; end
      5'b01000: begin w_f3 = 3'b000; end
      5'b01001: begin w_f3 = 3'b001; end
      5'b01010: begin w_f3 = 3'b010; end
      5'b01011: begin w_f7 = 7'd1; w_f3 = 3'b000; end
      5'b01100: begin w_f7 = 7'd1; w_f3 = 3'b001; end
      5'b01101: begin w_f7 = 7'd1; w_f3 = 3'b010; end
      5'b01110: begin w_f7 = 7'd1; w_f3 = 3'b011; end
      5'b01111: begin w_f7 = 7'd2; w_f3 = 3'b000; end
      5'b10000: begin w_f7 = 7'd2; w_f3 = 3'b001; end
      5'b10001: begin w_f7 = 7'd3; w_f3 = 3'b000; w_rs2 = 5'd0; end
      default:  begin w_legal = 1'b0; end
    endcase
    w_word = {w_f7, w_rs2, in_rs1, w_f3, in_rd, w_opcode};
  end

  assign in_ready    = (r_count != CW'(DEPTH));
  assign out_valid   = (r_count != '0);
  assign out_instr   = out_valid ? r_mem[r_rptr] : 32'd0;
  assign out_addr    = r_addr;
  assign err_illegal = r_err_illegal;
  assign word_count  = r_word_count;

  // Transfers coinciding with reset or flush are dropped.
  assign w_accept = in_valid & in_ready & reset & ~flush;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = out_valid & out_ready & reset & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_addr        <= BASE_ADDR;
      r_err_illegal <= 1'b0;
      r_word_count  <= 16'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_legal) r_err_illegal <= 1'b1;
      if (w_pop) begin
        r_addr <= r_addr + 32'd4;
        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end
    end
  end

`ifdef RVX10_ENC_CHECK_EN
  logic [4:0] r_mem_op [DEPTH];
  logic       r_chk_err;
  logic       w_dec_ok;
  logic [4:0] w_dec_op;
  logic [6:0] w_h_opc;
  logic [6:0] w_h_f7;
  logic [2:0] w_h_f3;

  // Independent inverse of the encoder table, applied to the FIFO head word.
  always_comb begin
    w_h_opc  = out_instr[6:0];
    w_h_f7   = out_instr[31:25];
    w_h_f3   = out_instr[14:12];
    w_dec_ok = 1'b1;
    w_dec_op = 5'd0;
    case ({w_h_opc, w_h_f7, w_h_f3})
      {OPC_BASE,  7'b0000000, 3'b000}: w_dec_op = 5'b00000;
      {OPC_BASE,  7'b0100000, 3'b000}: w_dec_op = 5'b00001;
      {OPC_BASE,  7'b0000000, 3'b111}: w_dec_op = 5'b00010;
      {OPC_BASE,  7'b0000000, 3'b110}: w_dec_op = 5'b00011;
      {OPC_BASE,  7'b0000000, 3'b010}: w_dec_op = 5'b00101;
      {OPC_RVX10, 7'b0000000, 3'b000}: w_dec_op = 5'b01000;
      {OPC_RVX10, 7'b0000000, 3'b001}: w_dec_op = 5'b01001;
      {OPC_RVX10, 7'b0000000, 3'b010}: w_dec_op = 5'b01010;
      {OPC_RVX10, 7'b0000001, 3'b000}: w_dec_op = 5'b01011;
      {OPC_RVX10, 7'b0000001, 3'b001}: w_dec_op = 5'b01100;
      {OPC_RVX10, 7'b0000001, 3'b010}: w_dec_op = 5'b01101;
      {OPC_RVX10, 7'b0000001, 3'b011}: w_dec_op = 5'b01110;
      {OPC_RVX10, 7'b0000010, 3'b000}: w_dec_op = 5'b01111;
      {OPC_RVX10, 7'b0000010, 3'b001}: w_dec_op = 5'b10000;
      {OPC_RVX10, 7'b0000011, 3'b000}: w_dec_op = 5'b10001;
      default:                         w_dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_op[r_wptr] <= in_op;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_chk_err <= 1'b0;
    end else if (w_pop && (!w_dec_ok || (w_dec_op != r_mem_op[r_rptr]))) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvx10_instr_encoder.sv
// Bench for rvx10_instr_encoder: directed steps followed by random traffic, all checked
// against a queue-based reference model built from the op table.
module tb_rvx10_instr_encoder;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_illegal;
  logic [15:0] word_count;
  logic        chk_err;

  // clock / reset block
  always #5 clk = ~clk;

  rvx10_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .word_count(word_count), .chk_err(chk_err)
  );

  // reference model state
  int          tbl_ok  [32];
  int          tbl_opc [32];
  int          tbl_f7  [32];
  int          tbl_f3  [32];
  logic [31:0] exp_q[$];
  logic [31:0] m_addr;
  int          m_count;
  logic        m_err;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int op, input int opc, input int f7, input int f3);
    tbl_ok[op] = 1; tbl_opc[op] = opc; tbl_f7[op] = f7; tbl_f3[op] = f3;
  endtask

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1, input int rs2);
    int r2;
    r2 = (op == 17) ? 0 : rs2;   // abs ignores rs2
    return 32'(tbl_f7[op] * (1 << 25) + r2 * (1 << 20) + rs1 * (1 << 15)
               + tbl_f3[op] * (1 << 12) + rd * (1 << 7) + tbl_opc[op]);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_addr  = BASE_ADDR;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("in_ready",    {31'd0, in_ready},    {31'd0, exp_q.size() != DEPTH});
    chk("out_valid",   {31'd0, out_valid},   {31'd0, exp_q.size() != 0});
    chk("out_instr",   out_instr,            (exp_q.size() != 0) ? exp_q[0] : 32'd0);
    chk("out_addr",    out_addr,             m_addr);
    chk("word_count",  {16'd0, word_count},  32'(m_count));
    chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
    chk("chk_err",     {31'd0, chk_err},     32'd0);
  endtask

  // one clock: check, let the edge happen, advance the model from pre-edge inputs
  task automatic cycle();
    bit acc, pop, clr;
    logic [31:0] w;
    check_outputs();
    clr = (reset == 1'b0) || (flush == 1'b1);
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() > 0);
    w   = ref_word(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2));
    @(posedge clk);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_addr = m_addr + 32'd4;
        if (m_count < 65535) m_count++;
      end
      if (acc) begin
        if (tbl_ok[int'(in_op)] != 0) exp_q.push_back(w);
        else m_err = 1'b1;
      end
    end
  endtask

  // driver tasks
  task automatic drive_op(input int op, input int rd, input int rs1, input int rs2);
    in_valid = 1'b1;
    in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
  endtask

  task automatic push(input int op, input int rd, input int rs1, input int rs2);
    drive_op(op, rd, rs1, rs2);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_ok[i] = 0; tbl_opc[i] = 0; tbl_f7[i] = 0; tbl_f3[i] = 0;
    end
    set_op(0, 51, 0, 0);   set_op(1, 51, 32, 0);  set_op(2, 51, 0, 7);
    set_op(3, 51, 0, 6);   set_op(5, 51, 0, 2);
    set_op(8, 11, 0, 0);   set_op(9, 11, 0, 1);   set_op(10, 11, 0, 2);
    set_op(11, 11, 1, 0);  set_op(12, 11, 1, 1);  set_op(13, 11, 1, 2);
    set_op(14, 11, 1, 3);  set_op(15, 11, 2, 0);  set_op(16, 11, 2, 1);
    set_op(17, 11, 3, 0);
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;

    // reset state
    reset_dut();
    chk("rst_in_ready",   {31'd0, in_ready},  32'd1);
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr",   out_addr,           32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    chk("rst_out_instr",  out_instr,          32'd0);

    // single andn word
    out_ready = 1'b1;
    push(8, 5, 6, 7);
    chk("andn_word", out_instr, 32'h0073028B);
    chk("andn_addr", out_addr, 32'd0);
    idle(2);

    // sub / abs / ror back to back with the sink always ready
    reset_dut();
    out_ready = 1'b1;
    push(1, 1, 2, 3);
    chk("sub_word", out_instr, 32'h403100B3);
    chk("sub_addr", out_addr, 32'd0);
    push(17, 10, 11, 31);
    chk("abs_word", out_instr, 32'h0605850B);
    chk("abs_addr", out_addr, 32'd4);
    push(16, 4, 4, 9);
    chk("ror_word", out_instr, 32'h0492120B);
    chk("ror_addr", out_addr, 32'd8);
    idle(2);
    chk("three_count", {16'd0, word_count}, 32'd3);

    // fill to full with the sink stalled, then release
    reset_dut();
    for (int i = 0; i < DEPTH; i++) push(8 + i, i + 1, i + 2, i + 3);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive_op(14, 20, 21, 22);
    idle(2);
    out_ready = 1'b1;
    cycle();
    chk("freed_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    in_valid = 1'b0;
    idle(6);
    chk("full_count", {16'd0, word_count}, 32'(DEPTH + 1));
    chk("full_addr", out_addr, 32'(4 * (DEPTH + 1)));

    // illegal op then andn
    reset_dut();
    push(4, 1, 1, 1);
    chk("illegal_err", {31'd0, err_illegal}, 32'd1);
    chk("illegal_empty", {31'd0, out_valid}, 32'd0);
    push(8, 5, 6, 7);
    chk("illegal_then_andn", out_instr, 32'h0073028B);
    chk("illegal_then_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    idle(2);
    chk("illegal_count", {16'd0, word_count}, 32'd1);

    // flush with two words queued and a transfer presented in the same cycle
    out_ready = 1'b0;
    push(0, 3, 4, 5);
    push(2, 6, 7, 8);
    push(6, 0, 0, 0);
    drive_op(3, 9, 9, 9);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_addr", out_addr, BASE_ADDR);
    chk("flush_err", {31'd0, err_illegal}, 32'd0);
    chk("flush_count", {16'd0, word_count}, 32'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_op     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(8, 17));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(DEPTH + 2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
